// File: rtl/dsp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dsp_pkg : shared sample width, gain range and saturation limits            |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
package dsp_pkg;

   localparam int DSP_WIDTH   = 18;
   localparam int GAIN_SH_W   = 2;
   localparam int GAIN_SH_MAX = 3;

   typedef enum logic {
      PHASE_EVEN = 1'b0,
      PHASE_ODD  = 1'b1
   } phase_e;

   function automatic longint sat_max_f(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min_f(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

   localparam longint SAT_MAX = sat_max_f(DSP_WIDTH);
   localparam longint SAT_MIN = sat_min_f(DSP_WIDTH);

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sample_fifo : first-word-fall-through sample FIFO, same-edge push/pop      |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module sample_fifo
   import dsp_pkg::*;
#(
   parameter int WIDTH = DSP_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                       sys_clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign do_push = push && (!full || do_pop);
   assign data    = mem[rd_ptr];

   always_ff @(posedge sys_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/hb_decim2_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hb_decim2_out : halfband output decimate-by-2, gain shift, saturate, FIFO  |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module hb_decim2_out
   import dsp_pkg::*;
#(
   parameter int WIDTH = DSP_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                    sys_clk,
   input  logic                    reset,
   input  logic                    in_en,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic                    dec_phase,
   input  logic [GAIN_SH_W-1:0]    gain_sh,
   input  logic                    out_ready,
   input  logic                    ovf_clr,
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] y_out,
   output logic                    sat_flag,
   output logic                    ovf
);

   localparam int     PW     = WIDTH + GAIN_SH_MAX;
   localparam int     CW     = $clog2(DEPTH + 1);
   localparam longint SAT_HI = (WIDTH == DSP_WIDTH) ? SAT_MAX : sat_max_f(WIDTH);
   localparam longint SAT_LO = (WIDTH == DSP_WIDTH) ? SAT_MIN : sat_min_f(WIDTH);
   localparam logic signed [PW-1:0] LIM_HI = PW'(SAT_HI);
   localparam logic signed [PW-1:0] LIM_LO = PW'(SAT_LO);

   phase_e                  phase;
   logic                    keep;
   logic signed [PW-1:0]    x_ext;
   logic signed [PW-1:0]    scaled;
   logic                    clip_hi;
   logic                    clip_lo;
   logic signed [WIDTH-1:0] sat_val;

   logic                    s1_valid;
   logic signed [WIDTH-1:0] s1_data;
   logic signed [WIDTH-1:0] hold;

   logic [WIDTH-1:0]        fifo_data;
   logic [CW-1:0]           fifo_count;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    pop;
   logic                    drop;

   assign keep    = in_en && (phase == phase_e'(dec_phase));
   assign x_ext   = PW'(x_in);
   assign scaled  = x_ext <<< gain_sh;
   assign clip_hi = (scaled > LIM_HI);
   assign clip_lo = (scaled < LIM_LO);

   always_comb begin
      sat_val = scaled[WIDTH-1:0];
      if (clip_hi) begin
         sat_val = LIM_HI[WIDTH-1:0];
      end else if (clip_lo) begin
         sat_val = LIM_LO[WIDTH-1:0];
      end
   end

   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid && out_ready;
   assign drop      = s1_valid && fifo_full && !pop;
   // Once drained, y_out keeps showing the last sample that left the FIFO.
   assign y_out     = fifo_empty ? hold : $signed(fifo_data);

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         phase    <= PHASE_EVEN;
         s1_valid <= 1'b0;
         s1_data  <= '0;
         sat_flag <= 1'b0;
         ovf      <= 1'b0;
         hold     <= '0;
      end else begin
         if (in_en) begin
            phase <= (phase == PHASE_EVEN) ? PHASE_ODD : PHASE_EVEN;
         end
         s1_valid <= keep;
         if (keep) begin
            s1_data <= sat_val;
         end
         sat_flag <= keep && (clip_hi || clip_lo);
         if (drop) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
         if (pop) begin
            hold <= $signed(fifo_data);
         end
      end
   end

   sample_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .reset     (reset),
      .push      (s1_valid),
      .push_data (s1_data),
      .pop       (pop),
      .data      (fifo_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule
`default_nettype wire

// File: tb/tb_hb_decim2_out.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hb_decim2_out : directed self-checking bench for hb_decim2_out          |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_hb_decim2_out;

   logic               sys_clk = 1'b0;
   logic               reset;
   logic               in_en;
   logic signed [17:0] x_in;
   logic               dec_phase;
   logic [1:0]         gain_sh;
   logic               out_ready;
   logic               ovf_clr;
   logic               out_valid;
   logic signed [17:0] y_out;
   logic               sat_flag;
   logic               ovf;

   int errors = 0;
   int checks = 0;

   hb_decim2_out #(.WIDTH(18), .DEPTH(4)) dut (
      .sys_clk   (sys_clk),
      .reset     (reset),
      .in_en     (in_en),
      .x_in      (x_in),
      .dec_phase (dec_phase),
      .gain_sh   (gain_sh),
      .out_ready (out_ready),
      .ovf_clr   (ovf_clr),
      .out_valid (out_valid),
      .y_out     (y_out),
      .sat_flag  (sat_flag),
      .ovf       (ovf)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // Kept sample followed by a discarded one; checks value, flag and 2-edge latency.
   task automatic keep_one(input int x, input int y_exp, input int sat_exp);
      in_en = 1'b1; x_in = 18'(x);
      tick();
      in_en = 1'b0;
      check_eq("gain_sat_flag", sat_flag, sat_exp);
      tick();
      check_eq("gain_valid", out_valid, 1);
      check_eq("gain_y", y_out, y_exp);
      check_eq("gain_sat_clear", sat_flag, 0);
      in_en = 1'b1; x_in = 18'sd0;
      tick();
      in_en = 1'b0;
      check_eq("gain_discard_sat", sat_flag, 0);
      tick();
      check_eq("gain_drained", out_valid, 0);
   endtask

   task automatic pair(input int x);
      in_en = 1'b1; x_in = 18'(x);
      tick();
      x_in = 18'sd999;
      tick();
      in_en = 1'b0;
   endtask

   initial begin
      int outs[$];
      int exp6[3];
      exp6 = '{10, 11, 13};

      reset = 1'b1; in_en = 1'b0; x_in = '0; dec_phase = 1'b0;
      gain_sh = 2'd0; out_ready = 1'b0; ovf_clr = 1'b0;
      tick(); tick();
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_y", y_out, 0);
      check_eq("rst_sat", sat_flag, 0);
      check_eq("rst_ovf", ovf, 0);

      // Basic decimation, in_en every second cycle
      reset = 1'b0; out_ready = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         in_en = 1'b1; x_in = 18'(i);
         tick();
         in_en = 1'b0;
         check_eq("dec_valid_early", out_valid, 0);
         tick();
         check_eq("dec_valid", out_valid, i % 2);
         if (i % 2 == 1) check_eq("dec_y", y_out, i);
      end

      // Gain and saturation
      gain_sh = 2'd2;
      keep_one(40000, 131071, 1);
      keep_one(-40000, -131072, 1);
      keep_one(1000, 4000, 0);
      keep_one(32767, 131068, 0);
      keep_one(32768, 131071, 1);
      keep_one(-32768, -131072, 0);
      gain_sh = 2'd0;

      // Overflow: six kept samples into a depth-4 FIFO with no consumer
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) pair(101 + k);
      tick(); tick();
      check_eq("ovf_valid", out_valid, 1);
      check_eq("ovf_set", ovf, 1);
      check_eq("ovf_head", y_out, 101);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_eq("ovf_drain_valid", out_valid, 1);
         check_eq("ovf_drain_y", y_out, 101 + k);
         tick();
      end
      check_eq("ovf_drain_empty", out_valid, 0);
      check_eq("ovf_empty_hold", y_out, 104);
      tick();
      check_eq("ovf_hold_ready", y_out, 104);
      check_eq("ovf_sticky", ovf, 1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check_eq("ovf_cleared", ovf, 0);

      // Full FIFO with simultaneous push and pop, across pointer wrap
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) pair(201 + k);
      tick();
      check_eq("full_valid", out_valid, 1);
      for (int k = 0; k < 2; k++) begin
         in_en = 1'b1; x_in = 18'(205 + k);
         tick();
         out_ready = 1'b1; x_in = 18'sd999;
         tick();
         out_ready = 1'b0; in_en = 1'b0;
         check_eq("pp_ovf", ovf, 0);
         check_eq("pp_head", y_out, 202 + k);
      end
      tick();
      check_eq("pp_ovf_after", ovf, 0);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_eq("pp_drain_valid", out_valid, 1);
         check_eq("pp_drain_y", y_out, 203 + k);
         tick();
      end
      check_eq("pp_drain_empty", out_valid, 0);

      // dec_phase change mid-stream
      for (int k = 0; k < 4; k++) begin
         if (k == 1) dec_phase = 1'b1;
         in_en = 1'b1; x_in = 18'(10 + k);
         tick();
         in_en = 1'b0;
         if (out_valid) outs.push_back(int'(y_out));
         tick();
         if (out_valid) outs.push_back(int'(y_out));
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         if (out_valid) outs.push_back(int'(y_out));
      end
      check_eq("ph_count", outs.size(), 3);
      for (int k = 0; k < 3; k++) begin
         if (k < outs.size()) check_eq("ph_y", outs[k], exp6[k]);
      end

      // Reset mid-stream with samples queued and the phase counter odd
      dec_phase = 1'b0; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) pair(301 + k);
      dec_phase = 1'b1;
      in_en = 1'b1; x_in = 18'sd999;
      tick();
      in_en = 1'b0;
      tick(); tick();
      check_eq("prerst_valid", out_valid, 1);
      check_eq("prerst_y", y_out, 301);
      dec_phase = 1'b0; reset = 1'b1;
      tick();
      check_eq("midrst_valid", out_valid, 0);
      check_eq("midrst_y", y_out, 0);
      check_eq("midrst_ovf", ovf, 0);
      reset = 1'b0; out_ready = 1'b1;
      tick();
      check_eq("postrst_stale", out_valid, 0);
      in_en = 1'b1; x_in = 18'sd77;
      tick();
      in_en = 1'b0;
      tick();
      check_eq("postrst_valid", out_valid, 1);
      check_eq("postrst_y", y_out, 77);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
